ks_digit_serial_adder: RTL

KS_DIGIT_SERIAL_ADDER -- requirements
Module: ks_digit_serial_adder

---
 rtl/ks_digit_serial_adder.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/ks_digit_serial_adder.sv
// Digit-serial adder: adds two WIDTH-bit operands plus a carry-in one 4-bit digit per
// cycle through a single 4-bit Kogge-Stone adder, least significant digit first.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operand set presented
//   in_ready   block can accept operands (IDLE and not in reset)
//   a, b       WIDTH-bit operands
//   cin        carry-in of the whole operation
//   out_valid  result available (DONE)
//   out_ready  consumer accepts result
//   sum        registered result a+b+cin mod 2^WIDTH
//   cout       registered carry-out of bit WIDTH-1

module ks_digit_serial_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned NDIG = WIDTH / 4;
  localparam int unsigned CntW = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              carry_q, carry_d;
  logic              cout_q, cout_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic [3:0]        ks_sum;
  logic              ks_cout;
  logic [WIDTH-1:0]  sum_shift;
  logic              last_digit;

  kogge_stone_4 u_adder (
    .a    (a_q[3:0]),
    .b    (b_q[3:0]),
    .cin  (carry_q),
    .sum  (ks_sum),
    .cout (ks_cout)
  );

  // New digit enters at the MSB end; after NDIG shifts digit 0 sits in bits 3:0.
  if (WIDTH == 4) begin : g_single_digit
    assign sum_shift = ks_sum;
  end else begin : g_multi_digit
    assign sum_shift = {ks_sum, sum_q[WIDTH-1:4]};
  end

  assign last_digit = (cnt_q == CntW'(NDIG - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        a_d     = a_q >> 4;
        b_d     = b_q >> 4;
        sum_d   = sum_shift;
        carry_d = ks_cout;
        cnt_d   = cnt_q + 1'b1;
        if (last_digit) begin
          cout_d  = ks_cout;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == StIdle) && !rst;
  assign out_valid = (state_q == StDone);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// 4-bit Kogge-Stone parallel-prefix adder with carry-in.
//   a, b  4-bit addends; cin carry-in; sum 4-bit sum; cout carry-out of bit 3
module kogge_stone_4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] g0, p0, g1, p1, g2, p2;
  logic [4:0] c;

  assign g0 = a & b;
  assign p0 = a ^ b;

  // Span 1
  assign g1[0] = g0[0];
  assign p1[0] = p0[0];
  assign g1[1] = g0[1] | (p0[1] & g0[0]);
  assign p1[1] = p0[1] & p0[0];
  assign g1[2] = g0[2] | (p0[2] & g0[1]);
  assign p1[2] = p0[2] & p0[1];
  assign g1[3] = g0[3] | (p0[3] & g0[2]);
  assign p1[3] = p0[3] & p0[2];

  // Span 2: g2[i]/p2[i] now cover bits i..0
  assign g2[0] = g1[0];
  assign p2[0] = p1[0];
  assign g2[1] = g1[1];
  assign p2[1] = p1[1];
  assign g2[2] = g1[2] | (p1[2] & g1[0]);
  assign p2[2] = p1[2] & p1[0];
  assign g2[3] = g1[3] | (p1[3] & g1[1]);
  assign p2[3] = p1[3] & p1[1];

  assign c[0] = cin;
  assign c[1] = g2[0] | (p2[0] & cin);
  assign c[2] = g2[1] | (p2[1] & cin);
  assign c[3] = g2[2] | (p2[2] & cin);
  assign c[4] = g2[3] | (p2[3] & cin);

  assign sum  = p0 ^ c[3:0];
  assign cout = c[4];

endmodule
